nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-word adder that adds two `4*NIBBLES`-bit operands one nibble per clock, using the existing 4-bit ripple adder `adder_4bit_proc` as its datapath. It sits directly upstream of `adder_4bit_proc`: it registers operands and carry and feeds the adder one nibble at a time. It also consumes the adder's `sum_out`/`carry_out` to assemble the wide result. Operands arrive and results leave on valid/ready handshakes, so the block drops into any wider arithmetic path without a wide combinational carry chain.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles per operand; legal range 1..16.
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: operand word valid.
- `in_ready`, out, 1: block can accept operands; high only in IDLE.
- `in_a`, in, 4*NIBBLES: operand A.
- `in_b`, in, 4*NIBBLES: operand B.
- `in_cin`, in, 1: carry into nibble 0.
- `out_valid`, out, 1: result valid; high only in DONE.
- `out_ready`, in, 1: downstream accepts the result.
- `out_sum`, out, 4*NIBBLES: `(in_a + in_b + in_cin) mod 2^(4*NIBBLES)`.
- `out_cout`, out, 1: carry out of the top nibble.
- `busy`, out, 1: high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`:
  - latch `in_a`, `in_b` into shift registers `a_q`, `b_q`;
  - set carry register `c_q` to `in_cin`;
  - clear nibble counter `idx` and result register `s_q`;
  - go to RUN.
- **RUN:** the adder sees `a_q[3:0]`, `b_q[3:0]` and `c_q`. Each edge:
  - `a_q` and `b_q` shift right by 4;
  - adder `sum_out` shifts into the top nibble of `s_q` (`s_q` shifts right by 4);
  - `c_q` takes `carry_out`;
  - `idx` increments.
  - When `idx == NIBBLES-1` at the edge, go to DONE.
- **DONE:** `out_valid`=1, `out_sum`=`s_q`, `out_cout`=`c_q`. Both hold stable until `out_valid && out_ready`, then go to IDLE.
- In RUN and DONE, `in_valid` is ignored and `in_ready`=0. A result handshake and a new operand accept never occur in the same cycle.
- Operand inputs are sampled only at the accept edge and may change freely afterwards.
- `idx` width is `$clog2(NIBBLES)`, minimum 1 bit. It is never compared against values ≥ NIBBLES.
- `NIBBLES`=1 gives exactly one RUN cycle.

## Timing
- **Reset values** (asserted asynchronously on `rst_n` low):
  - state=IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `out_sum`=0, `out_cout`=0;
  - `a_q`, `b_q`, `s_q`, `c_q`, `idx` all 0.
- **Latency:**
  - Accept on edge k: RUN occupies cycles k+1..k+NIBBLES.
  - `out_valid` rises after edge k+NIBBLES.
  - Earliest result handshake is edge k+NIBBLES+1; IDLE follows.
  - Next accept is no earlier than edge k+NIBBLES+2.
  - Maximum throughput is one word per NIBBLES+2 cycles.
- **Reset mid-operation:** state and all registers clear immediately. The partial result is discarded with no `out_valid` pulse. Normal operation resumes on the first edge after `rst_n` rises.
- **Backpressure:** with `out_ready` held low, DONE persists indefinitely with `out_sum`/`out_cout` unchanged.
- `out_sum` and `out_cout` are driven directly from registers; there is no combinational path from inputs to outputs.
- `in_ready` and `out_valid` are decoded from the state register only.

## Structure
- Package `nibble_adder_pkg`:
  - `localparam NIBBLE_W = 4`;
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t`.
- One sub-module: the existing `adder_4bit_proc`, instantiated once, with ports `ina`, `inb`, `carry_in`, `sum_out`, `carry_out`.
- FSM, shift registers and counter live in `nibble_serial_adder`.

## Test plan
All scenarios use `NIBBLES`=4.
- **Reset:** `rst_n` low, then high → `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0x0000, `out_cout`=0.
- **Basic add:** a=0x1234, b=0x4321, cin=0 → `out_sum`=0x5555, `out_cout`=0. `out_valid` rises exactly 4 edges after the accept edge; `busy`=1 throughout.
- **Ripple across all nibbles:** a=0xFFFF, b=0x0001, cin=0 → `out_sum`=0x0000, `out_cout`=1.
- **Max operands with carry-in:** a=0xFFFF, b=0xFFFF, cin=1 → `out_sum`=0xFFFF, `out_cout`=1.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new data → result stable, `in_ready`=0, new data not taken.
  - Raise `out_ready` → IDLE next cycle. The next word, a=0x0F0F, b=0x00F1, cin=1, is accepted and yields 0x1001, `out_cout`=0.
- **Reset mid-RUN:**
  - Pulse `rst_n` low after 2 RUN cycles of a=0xAAAA, b=0x5555 → outputs clear immediately and no `out_valid` appears.
  - Then a=0x8000, b=0x8000, cin=0 → `out_sum`=0x0000, `out_cout`=1.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W     - width of one datapath slice (one nibble)
//   nsa_state_t  - controller state encoding
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage : nibble_adder_pkg

// File: rtl/adder_4bit_proc.sv
// 4-bit ripple-carry adder, purely combinational.
// Ports:
//   ina, inb   - 4-bit addends
//   carry_in   - carry into bit 0
//   sum_out    - 4-bit sum
//   carry_out  - carry out of bit 3
module adder_4bit_proc (
    input  logic [3:0] ina,
    input  logic [3:0] inb,
    input  logic       carry_in,
    output logic [3:0] sum_out,
    output logic       carry_out
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum_out  = '0;
        carry[0] = carry_in;
        for (int i = 0; i < 4; i++) begin
            sum_out[i]   = ina[i] ^ inb[i] ^ carry[i];
            carry[i + 1] = (ina[i] & inb[i]) | (carry[i] & (ina[i] ^ inb[i]));
        end
        carry_out = carry[4];
    end

endmodule : adder_4bit_proc

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one nibble per clock through a single 4-bit
// ripple adder. Operands are taken on a valid/ready handshake, the sum is
// assembled nibble by nibble and offered on a second valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per edge, NIBBLES edges total
// DONE  | result held on out_sum/out_cout until out_ready
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - operand handshake
//   in_a, in_b, in_cin    - operands and carry into nibble 0
//   out_valid/out_ready   - result handshake
//   out_sum, out_cout     - registered result and carry out of top nibble
//   busy                  - high in RUN or DONE
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NIBBLES-1:0]      in_a,
    input  logic [4*NIBBLES-1:0]      in_b,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NIBBLES-1:0]      out_sum,
    output logic                      out_cout,
    output logic                      busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nsa_state_t         state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       s_q;
    logic               c_q;
    logic [IDX_W-1:0]   idx;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [W-1:0]        nib_sum_top;

    adder_4bit_proc u_adder (
        .ina       (a_q[NIBBLE_W-1:0]),
        .inb       (b_q[NIBBLE_W-1:0]),
        .carry_in  (c_q),
        .sum_out   (nib_sum),
        .carry_out (nib_cout)
    );

    // New nibble lands in the top slot; written as a shift so that the
    // single-nibble configuration needs no special case.
    assign nib_sum_top = W'(nib_sum) << (W - NIBBLE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        c_q   <= in_cin;
                        s_q   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q <= a_q >> NIBBLE_W;
                    b_q <= b_q >> NIBBLE_W;
                    s_q <= (s_q >> NIBBLE_W) | nib_sum_top;
                    c_q <= nib_cout;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign out_sum   = s_q;
    assign out_cout  = c_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word in IDLE and return just after the accept edge.
    task automatic start_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_cin   = 1'b1;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Walk the NIBBLES RUN edges, checking out_valid rises on the last one.
    task automatic run_check(input string tag, input logic [W-1:0] exp_sum, input logic exp_cout);
        for (int i = 1; i <= NIBBLES; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_out_valid_edge"}, 32'(out_valid), (i == NIBBLES) ? 32'd1 : 32'd0);
        end
        chk({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'h0000);
        chk("rst_cout", 32'(out_cout), 32'd0);

        // Basic add
        start_word(16'h1234, 16'h4321, 1'b0);
        run_check("basic", 16'h5555, 1'b0);
        take_result("basic");

        // Ripple across all nibbles
        start_word(16'hFFFF, 16'h0001, 1'b0);
        run_check("ripple", 16'h0000, 1'b1);
        take_result("ripple");

        // Max operands with carry-in, then backpressure with new data offered
        start_word(16'hFFFF, 16'hFFFF, 1'b1);
        run_check("max", 16'hFFFF, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_cin   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum", 32'(out_sum), 32'hFFFF);
            chk("bp_cout", 32'(out_cout), 32'd1);
        end
        @(negedge clk);
        in_a      = 16'h0F0F;
        in_b      = 16'h00F1;
        in_cin    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        // in_valid still high: accepted on the next edge
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'h0000;
        in_b     = 16'h0000;
        in_cin   = 1'b0;
        chk("bp_next_accept_busy", 32'(busy), 32'd1);
        run_check("bp_next", 16'h1001, 1'b0);
        take_result("bp_next");

        // Reset mid-RUN
        start_word(16'hAAAA, 16'h5555, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_partial_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(out_sum), 32'h0000);
        chk("midrst_cout", 32'(out_cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
            chk("midrst_idle_busy", 32'(busy), 32'd0);
        end

        start_word(16'h8000, 16'h8000, 1'b0);
        run_check("after_rst", 16'h0000, 1'b1);
        take_result("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nibble_serial_adder
